// File: rtl/mul_sequencer.sv
// mul_sequencer: sequences the shared multiply_unit for MUL/MLA and the
// long multiply forms (UMULL/SMULL/UMLAL/SMLAL).
//
// Flow: IDLE -> LOAD -> WAIT (MUL_CYCLES cycles) -> WB_LO [-> WB_HI] -> IDLE.
// All outputs are decoded from registered state and latched instruction
// fields only, so there is no combinational path from start/ir to outputs.
//
// Build option: define MUL_LONG_EN to support the long forms (ir[23] = 1).
// Without it, WB_HI is absent, mul_hilo is tied to 0, and a long encoding
// produces a one-cycle undef pulse while the block stays in IDLE.
//
// Handshake: start is a one-cycle request sampled only in IDLE with ir valid
// in the same cycle; it is dropped (not queued) while busy. done is a
// one-cycle pulse in the final writeback cycle; a new start is accepted in
// the cycle after done. flush aborts from any state and wins over start.
module mul_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] ir,
  output logic [3:0]  rd_sel_a,
  output logic [3:0]  rd_sel_b,
  output logic        ld_mul,
  output logic        mul_hilo,
  output logic        mul_u,
  output logic        mul_acc,
  output logic        gate_mul,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic        busy,
  output logic        done,
  output logic        undef
);

  // Counter start value: WAIT lasts exactly MUL_CYCLES cycles, counting
  // down from MUL_CYCLES-1 to 0 inclusive.
  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  // Register-bank index that must never be written by a multiply (PC).
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
`ifdef MUL_LONG_EN
    WB_LO = 3'd3,
    WB_HI = 3'd4
`else
    WB_LO = 3'd3
`endif
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       latch_en;
  logic       undef_next;
  logic       undef_q;

  // Latched instruction fields, captured when a start is accepted.
  logic [3:0] rm_q;
  logic [3:0] rs_q;
  logic [3:0] rd_hi_q;
  logic       u_q;
  logic       acc_q;
`ifdef MUL_LONG_EN
  logic [3:0] rd_lo_q;
  logic       long_q;
`endif

  // Instruction bits this block does not decode (condition, opcode body,
  // S bit, the 1001 signature and, without long support, RdLo).
  logic unused_ir;
`ifdef MUL_LONG_EN
  assign unused_ir = ^{ir[31:24], ir[20], ir[7:4]};
`else
  assign unused_ir = ^{ir[31:24], ir[20], ir[15:12], ir[7:4]};
`endif

  // A long request is legal only when long support is built in.
  logic long_req_bad;
`ifdef MUL_LONG_EN
  assign long_req_bad = 1'b0;
`else
  assign long_req_bad = ir[23];
`endif

  // State, wait counter and undef flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      undef_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      undef_q <= undef_next;
    end
  end

  // Instruction field latch; loaded only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_q    <= 4'd0;
      rs_q    <= 4'd0;
      rd_hi_q <= 4'd0;
      u_q     <= 1'b0;
      acc_q   <= 1'b0;
`ifdef MUL_LONG_EN
      rd_lo_q <= 4'd0;
      long_q  <= 1'b0;
`endif
    end else if (latch_en) begin
      rm_q    <= ir[3:0];
      rs_q    <= ir[11:8];
      rd_hi_q <= ir[19:16];
      u_q     <= ir[22];
      acc_q   <= ir[21];
`ifdef MUL_LONG_EN
      rd_lo_q <= ir[15:12];
      long_q  <= ir[23];
`endif
    end
  end

  // Next-state logic: flush first, then the per-state sequencing.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    undef_next = 1'b0;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (long_req_bad) begin
              undef_next = 1'b1;
            end else begin
              latch_en   = 1'b1;
              state_next = LOAD;
            end
          end
        end
        LOAD: begin
          cnt_next   = CNT_INIT;
          state_next = WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state_next = WB_LO;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        WB_LO: begin
`ifdef MUL_LONG_EN
          state_next = long_q ? WB_HI : IDLE;
`else
          state_next = IDLE;
`endif
        end
`ifdef MUL_LONG_EN
        WB_HI: begin
          state_next = IDLE;
        end
`endif
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and latched fields only.
  always_comb begin
    rd_sel_a = 4'd0;
    rd_sel_b = 4'd0;
    ld_mul   = 1'b0;
    mul_hilo = 1'b0;
    mul_u    = 1'b0;
    mul_acc  = 1'b0;
    gate_mul = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = 4'd0;
    busy     = (state != IDLE);
    done     = 1'b0;
    undef    = undef_q;
    if (state != IDLE) begin
      rd_sel_a = rm_q;
      rd_sel_b = rs_q;
      mul_u    = u_q;
      mul_acc  = acc_q;
    end
    case (state)
      LOAD: begin
        ld_mul = 1'b1;
      end
      WB_LO: begin
        gate_mul = 1'b1;
`ifdef MUL_LONG_EN
        wr_sel = long_q ? rd_lo_q : rd_hi_q;
        done   = ~long_q;
`else
        wr_sel = rd_hi_q;
        done   = 1'b1;
`endif
        wr_en = (wr_sel != REG_PC);
      end
`ifdef MUL_LONG_EN
      WB_HI: begin
        mul_hilo = 1'b1;
        gate_mul = 1'b1;
        wr_sel   = rd_hi_q;
        wr_en    = (rd_hi_q != REG_PC);
        done     = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  // Invariants of the sequencing.
  a_wait_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (state == WAIT) |-> (cnt <= CNT_INIT));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> !(ld_mul || gate_mul || wr_en || done));
  a_wr_gated: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> gate_mul);
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: randomized and directed multiply requests,
// checked by a cycle-stamped scoreboard fed from a timing-level model.
module tb_mul_sequencer;

  localparam int MC = 4;
`ifdef MUL_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  // Entry: {cycle[15:0], ld, rsa[3:0], rsb[3:0], u, acc, gate, wen,
  //         wsel[3:0], hilo, done, undef}
  localparam int W = 36;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] ir;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic        ld_mul;
  logic        mul_hilo;
  logic        mul_u;
  logic        mul_acc;
  logic        gate_mul;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic        busy;
  logic        done;
  logic        undef;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mul_sequencer #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .ir(ir),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .ld_mul(ld_mul),
    .mul_hilo(mul_hilo), .mul_u(mul_u), .mul_acc(mul_acc),
    .gate_mul(gate_mul), .wr_en(wr_en), .wr_sel(wr_sel), .busy(busy),
    .done(done), .undef(undef)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int free_cyc = 0;   // first cycle at which a start is accepted
  int busy_lo  = 0;   // busy window of the current instruction
  int busy_hi  = -1;

  function automatic logic [W-1:0] mk(input int c, input bit ld,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input bit u, input bit acc, input bit g,
                                      input bit we, input logic [3:0] ws,
                                      input bit hl, input bit dn, input bit un);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, ld, a, b, u, acc, g, we, ws, hl, dn, un};
  endfunction

  // Model: an accepted start at cycle c produces its events at fixed offsets.
  task automatic model_accept(input int c, input logic [31:0] i);
    logic [3:0] rm, rs, hi, lo;
    bit lng, u, a;
    int wb, last;
    rm = i[3:0]; rs = i[11:8]; lo = i[15:12]; hi = i[19:16];
    lng = i[23]; u = i[22]; a = i[21];
    if (lng && !LONG_EN) begin
      exp_q.push_back(mk(c + 1, 0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
      free_cyc = c + 1;
    end else begin
      exp_q.push_back(mk(c + 1, 1, rm, rs, u, a, 0, 0, 4'd0, 0, 0, 0));
      wb = c + 2 + MC;
      if (lng) begin
        exp_q.push_back(mk(wb, 0, rm, rs, u, a, 1, lo != 4'd15, lo, 0, 0, 0));
        exp_q.push_back(mk(wb + 1, 0, rm, rs, u, a, 1, hi != 4'd15, hi, 1, 1, 0));
        last = wb + 1;
      end else begin
        exp_q.push_back(mk(wb, 0, rm, rs, u, a, 1, hi != 4'd15, hi, 0, 1, 0));
        last = wb;
      end
      busy_lo  = c + 1;
      busy_hi  = last;
      free_cyc = last + 1;
    end
  endtask

  // Model: a flush at cycle c cancels every event scheduled after c.
  task automatic model_flush(input int c);
    logic [W-1:0] keep[$];
    foreach (exp_q[k]) begin
      if (int'(exp_q[k][W-1 -: 16]) <= c) keep.push_back(exp_q[k]);
    end
    exp_q = keep;
    if (c >= busy_lo && c <= busy_hi) busy_hi = c;
    if (free_cyc > c + 1) free_cyc = c + 1;
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs (called at posedge+1) and update the model.
  task automatic step(input bit s, input logic [31:0] i, input bit f);
    int c;
    c = cyc;
    start = s;
    ir    = i;
    flush = f;
    if (f) model_flush(c);
    else if (s && c >= free_cyc) model_accept(c, i);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) step(0, 32'd0, 0);
  endtask

  task automatic check_quiet(input string name);
    logic [20:0] v;
    v = {ld_mul, mul_hilo, mul_u, mul_acc, gate_mul, wr_en, busy, done, undef,
         rd_sel_a, rd_sel_b, wr_sel};
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected=0", name, v);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    logic [15:0]  c16;
    bit exp_busy;
    if (rst_n === 1'b1) begin
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy @%0d: got %b expected %b", cyc, busy, exp_busy);
      end
      if (ld_mul || gate_mul || wr_en || done || undef) begin
        c16 = cyc[15:0];
        act = {c16, ld_mul, rd_sel_a, rd_sel_b, mul_u, mul_acc, gate_mul,
               wr_en, wr_sel, mul_hilo, done, undef};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event @%0d: got %h expected none", cyc, act);
        end else begin
          exp_v = exp_q.pop_front();
          if (act !== exp_v) begin
            errors++;
            $display("FAIL event @%0d: got %h expected %h", cyc, act, exp_v);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] IR_MUL   = 32'hE002_0493; // Rd=2 Rm=3 Rs=4
  localparam logic [31:0] IR_SMULL = 32'hE0C6_5493; // RdHi=6 RdLo=5 signed
  localparam logic [31:0] IR_RD15  = 32'hE00F_0493; // Rd=15
  localparam logic [31:0] IR_MLA   = 32'hE027_8A9B; // Rd=7 Rm=11 Rs=10 acc
  localparam logic [31:0] IR_UMLAL = 32'hE0A9_F291; // RdHi=9 RdLo=15 acc

  initial begin : main
    int r;
    int guard;
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; ir = 32'd0;
    #1 rst_n = 1'b0;
    #1 check_quiet("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    free_cyc = cyc;

    // Directed forms, each issued in the first cycle the block is free.
    wait_free(); step(1, IR_MUL, 0);
    wait_free(); step(1, IR_SMULL, 0);
    wait_free(); step(1, IR_RD15, 0);
    wait_free(); step(1, IR_MLA, 0);
    wait_free(); step(1, IR_UMLAL, 0);

    // Flush in WAIT, then a start while busy that must be dropped.
    wait_free(); step(1, IR_MUL, 0);
    step(0, 32'd0, 0); step(0, 32'd0, 0);
    step(0, 32'd0, 1);
    repeat (8) step(0, 32'd0, 0);
    wait_free(); step(1, IR_MLA, 0);
    step(0, 32'd0, 0); step(0, 32'd0, 0);
    step(1, IR_SMULL, 0);
    wait_free();
    // Flush and start together in IDLE: flush wins.
    step(1, IR_MUL, 1);
    repeat (3) step(0, 32'd0, 0);

    // Reset in the middle of WAIT.
    wait_free(); step(1, IR_MUL, 0);
    step(0, 32'd0, 0); step(0, 32'd0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    busy_hi = -1;
    free_cyc = 0;
    #1 check_quiet("reset_mid_wait");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 32'd0, 0);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      step(1, $urandom, 0);
      else if (r < 45) step(0, 32'd0, 1);
      else             step(0, 32'd0, 0);
    end

    // Drain and confirm nothing is left outstanding.
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step(0, 32'd0, 0);
      guard++;
    end
    repeat (4) step(0, 32'd0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Sequences the shared `multiply_unit` for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL execution.
- The main `state_machine` hands it a multiply instruction with a one-cycle `start` pulse.
- It drives register-bank read selects and `LD_MUL`, waits out the multiplier latency, then gates `MUL_HiLo` results onto the B bus and into the register bank.
- It returns a `done` pulse when finished.
- It owns `GATE_MUL` exclusively; no other block drives `mul_out` onto `b_bus`.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: cycles between `LD_MUL` and a valid product; legal range 1..15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle request; `ir` is valid in the same cycle.
- `flush`, input, 1: synchronous abort (exception or pipeline flush).
- `ir`, input, 32: multiply instruction word.
- `rd_sel_a`, output, 4: register-bank read select, driven with Rm.
- `rd_sel_b`, output, 4: register-bank read select, driven with Rs.
- `ld_mul`, output, 1: drives `multiply_unit.LD_MUL`.
- `mul_hilo`, output, 1: drives `multiply_unit.MUL_HiLo`; 0 selects the low word, 1 the high word.
- `mul_u`, output, 1: latched `ir[22]` (signed for long forms).
- `mul_acc`, output, 1: latched `ir[21]` (accumulate; the add is performed downstream).
- `gate_mul`, output, 1: enables the `GATE_MUL` tristate onto `b_bus`.
- `wr_en`, output, 1: register-bank write enable.
- `wr_sel`, output, 4: register-bank write select.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `undef`, output, 1: one-cycle pulse for an unsupported encoding.

## Operation
States: IDLE, LOAD, WAIT, WB_LO, WB_HI.

Transitions:
- **IDLE:** `start` latches `ir` into an internal register.
  - Go to LOAD.
  - Exception: if `ir[23]` (long) is set and long support is compiled out, stay in IDLE and pulse `undef` next cycle.
- **LOAD:**
  - `rd_sel_a = ir[3:0]`, `rd_sel_b = ir[11:8]`, `ld_mul = 1`.
  - Load the wait counter with `MUL_CYCLES-1`, then go to WAIT.
- **WAIT:**
  - Counter decrements each cycle.
  - At 0, go to WB_LO. With `MUL_CYCLES = 1`, WAIT lasts exactly one cycle.
- **WB_LO:**
  - `mul_hilo = 0`, `gate_mul = 1`, `wr_en = 1`.
  - `wr_sel` = `ir[19:16]` (Rd) for short forms, `ir[15:12]` (RdLo) for long forms.
  - Short forms: assert `done` and go to IDLE. Long forms: go to WB_HI.
- **WB_HI:**
  - `mul_hilo = 1`, `gate_mul = 1`, `wr_en = 1`, `wr_sel = ir[19:16]` (RdHi).
  - Assert `done` and go to IDLE.

Rules:
- **Write suppression:** if `wr_sel` = 15 in a writeback state, `wr_en` is forced to 0. `gate_mul` and the state advance are unchanged.
- **Output defaults:** `rd_sel_*` hold the latched Rm/Rs in every non-IDLE state. All other outputs are 0 outside the states listed above.
- **`start` while busy:** ignored; no queueing.
- **`flush`:** in any state, next state is IDLE and no further `wr_en`/`done` is asserted. `flush` has priority over `start` in IDLE.
- **Mid-operation reset:** all outputs go to 0 immediately and the state returns to IDLE.

## Timing
- Reset values:
  - state = IDLE; counter = 0.
  - `ld_mul`, `mul_hilo`, `mul_u`, `mul_acc`, `gate_mul`, `wr_en`, `busy`, `done`, `undef` = 0.
  - `rd_sel_a`, `rd_sel_b`, `wr_sel` = 0.
- All outputs are decoded from registered state only. There is no combinational path from `start` or `ir` to any output.
- Short multiply: `start` at cycle 0 → LOAD at cycle 1 → WAIT at cycles 2..1+`MUL_CYCLES` → WB_LO plus `done` at cycle 2+`MUL_CYCLES`.
- Long multiply: adds WB_HI; `done` at cycle 3+`MUL_CYCLES`.
- Back-to-back: a new `start` is accepted in the cycle after `done`, because state is IDLE then.
- `undef`: pulsed one cycle after the rejected `start`; `busy` stays 0.

## Configuration
- `MUL_LONG_EN` defined: the long forms are supported (`ir[23]` = 1 executes WB_LO to RdLo, then WB_HI to RdHi).
- `MUL_LONG_EN` undefined:
  - The WB_HI state and `mul_hilo = 1` path are removed; `mul_hilo` is tied to 0.
  - `start` with `ir[23]` = 1 pulses `undef` and never leaves IDLE.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-WAIT → all outputs 0 the same cycle; after release, `busy` = 0.
- **MUL, `MUL_CYCLES` = 4:** `ir` with Rd = 2, Rm = 3, Rs = 4 →
  - `ld_mul` at cycle 1 with `rd_sel_a` = 3, `rd_sel_b` = 4.
  - `wr_en` plus `done` at cycle 6 with `wr_sel` = 2 and `mul_hilo` = 0.
- **SMULL, RdLo = 5, RdHi = 6, `MUL_LONG_EN` defined:**
  - `mul_u` = 1.
  - Cycle 6: `wr_sel` = 5, `mul_hilo` = 0.
  - Cycle 7: `wr_sel` = 6, `mul_hilo` = 1, `done` = 1.
- **Rd = 15:** writeback cycle shows `gate_mul` = 1, `wr_en` = 0, `done` = 1.
- **Flush and ignored start:**
  - `flush` in WAIT → IDLE next cycle; no `wr_en`/`done` pulses afterwards.
  - `start` pulsed during WAIT of an earlier instruction → ignored.
- **`MUL_LONG_EN` undefined, UMULL:** `undef` = 1 at cycle 1; `busy`, `ld_mul`, `wr_en` stay 0.
